// File: rtl/fp_result_collector_pkg.sv
// Shared types for the fp reciprocal result path: result/flag beats and pipeline latency.
package fp_result_collector_pkg;

    typedef logic [31:0] fp_32b_t;

    // IEEE exception flags in fflags CSR order.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    typedef struct packed {
        fp_32b_t   value;
        fp_flags_t flags;
    } fp_result_t;

    localparam int unsigned FP_RECIP_LATENCY = 4;
    localparam int unsigned FP_RESULT_W      = $bits(fp_result_t);

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock FIFO with registered storage; head reads zero while empty.
module fp_sync_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// Collects non-stallable fp reciprocal results into a FIFO, issues credits upstream and
// accumulates sticky IEEE flags plus protocol error bits.
module fp_result_collector
    import fp_result_collector_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_fire,
    output logic             issue_ok,
    input  logic             res_valid,
    input  logic [31:0]      res_data,
    input  logic [4:0]       res_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_flags,
    output logic [4:0]       fflags,
    input  logic             fflags_clear,
    output logic [CNT_W-1:0] reserved,
    output logic [1:0]       err_sticky
);

    logic [CNT_W-1:0] reserved_q, reserved_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [1:0]       err_q, err_d;

    fp_result_t       fifo_din, fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             pop, issue_acc, push_ok, push_drop;
    logic             fifo_count_unused;

    assign issue_ok  = (reserved_q < CNT_W'(DEPTH));
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign issue_acc = issue_fire & issue_ok;
    assign push_ok   = res_valid & (~fifo_full | pop);
    assign push_drop = res_valid & fifo_full & ~pop;

    assign fifo_din.value = res_data;
    assign fifo_din.flags = res_flags;

    fp_sync_fifo #(
        .WIDTH (FP_RESULT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_ok),
        .pop_i   (pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fifo_count_unused = ^fifo_count;

    always_comb begin
        reserved_d = reserved_q;
        if (issue_acc && !pop) begin
            reserved_d = reserved_q + 1'b1;
        end else if (!issue_acc && pop && reserved_q != '0) begin
            // Saturate: pops of beats never issued must not wrap the credit count.
            reserved_d = reserved_q - 1'b1;
        end

        fflags_d = fflags_q;
        if (push_ok) begin
            fflags_d = (fflags_clear ? 5'b0 : fflags_q) | res_flags;
        end else if (fflags_clear) begin
            fflags_d = 5'b0;
        end

        err_d = err_q | {push_drop, issue_fire & ~issue_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved_q <= '0;
            fflags_q   <= '0;
            err_q      <= '0;
        end else begin
            reserved_q <= reserved_d;
            fflags_q   <= fflags_d;
            err_q      <= err_d;
        end
    end

    assign out_data   = fifo_dout.value;
    assign out_flags  = fifo_dout.flags;
    assign fflags     = fflags_q;
    assign reserved   = reserved_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Scoreboard bench for fp_result_collector: credits, full-FIFO push, flags, random traffic,
// and asynchronous reset.
module tb_fp_result_collector;
    import fp_result_collector_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_fire, issue_ok;
    logic             res_valid;
    logic [31:0]      res_data;
    logic [4:0]       res_flags;
    logic             out_valid, out_ready;
    logic [31:0]      out_data;
    logic [4:0]       out_flags;
    logic [4:0]       fflags;
    logic             fflags_clear;
    logic [CNT_W-1:0] reserved;
    logic [1:0]       err_sticky;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [36:0] sb [$];

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [4:0]  f;
    } beat_t;

    fp_result_collector #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_fire   (issue_fire),
        .issue_ok     (issue_ok),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .fflags       (fflags),
        .fflags_clear (fflags_clear),
        .reserved     (reserved),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled at the following falling edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] f,
                         input logic rdy, input logic fire, input logic clr);
        res_valid    = v;
        res_data     = d;
        res_flags    = f;
        out_ready    = rdy;
        issue_fire   = fire;
        fflags_clear = clr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        res_valid = 0; res_data = '0; res_flags = '0; out_ready = 0;
        issue_fire = 0; fflags_clear = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({out_valid, out_data, out_flags, fflags, reserved, err_sticky, issue_ok} !==
            {1'b0, 32'h0, 5'h0, 5'h0, CNT_W'(0), 2'b00, 1'b1})
            $display("FAIL reset_state: got v=%b d=%h f=%b ff=%b res=%0d err=%b ok=%b want zeros/ok=1",
                     out_valid, out_data, out_flags, fflags, reserved, err_sticky, issue_ok);
        else pass_cnt++;
        drive(1, 32'h3F00_0000, 5'b0, 0, 0, 0);
        drive(0, 32'h0, 5'b0, 0, 0, 0);
        total_cnt++;
        if ({out_valid, out_data, fflags} !== {1'b1, 32'h3F00_0000, 5'b0})
            $display("FAIL first_beat: got v=%b d=%h ff=%b want v=1 d=3f000000 ff=0",
                     out_valid, out_data, fflags);
        else pass_cnt++;
        drive(0, 32'h0, 5'b0, 1, 0, 0);
        total_cnt++;
        if ({out_valid, out_data, out_flags} !== {1'b0, 32'h0, 5'h0})
            $display("FAIL empty_after_pop: got v=%b d=%h f=%b want 0", out_valid, out_data,
                     out_flags);
        else pass_cnt++;
    endtask

    task automatic test_credits();
        do_reset();
        for (int i = 0; i < 16; i++) drive(0, 32'h0, 5'b0, 0, 1, 0);
        total_cnt++;
        if ({reserved, issue_ok} !== {CNT_W'(16), 1'b0})
            $display("FAIL credits_full: got res=%0d ok=%b want res=16 ok=0", reserved, issue_ok);
        else pass_cnt++;
        drive(0, 32'h0, 5'b0, 0, 1, 0);
        total_cnt++;
        if ({err_sticky, reserved} !== {2'b01, CNT_W'(16)})
            $display("FAIL issue_no_credit: got err=%b res=%0d want err=01 res=16",
                     err_sticky, reserved);
        else pass_cnt++;
        drive(1, 32'h1234_5678, 5'b0, 0, 0, 0);
        drive(0, 32'h0, 5'b0, 1, 0, 0);
        total_cnt++;
        if ({issue_ok, reserved} !== {1'b1, CNT_W'(15)})
            $display("FAIL credit_return: got ok=%b res=%0d want ok=1 res=15", issue_ok, reserved);
        else pass_cnt++;
    endtask

    task automatic test_full_push();
        logic [36:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sb.push_back({32'h100 + 32'(i), 5'b0});
            drive(1, 32'h100 + 32'(i), 5'b0, 0, 0, 0);
        end
        total_cnt++;
        if ({out_valid, err_sticky} !== {1'b1, 2'b00})
            $display("FAIL fill16: got v=%b err=%b want v=1 err=00", out_valid, err_sticky);
        else pass_cnt++;
        // 17th beat with a simultaneous pop is accepted.
        exp = sb.pop_front();
        total_cnt++;
        if ({out_data, out_flags} !== exp)
            $display("FAIL full_pop_head: got %h want %h", {out_data, out_flags}, exp);
        else pass_cnt++;
        sb.push_back({32'h200, 5'b0});
        drive(1, 32'h200, 5'b0, 1, 0, 0);
        total_cnt++;
        if (err_sticky !== 2'b00)
            $display("FAIL full_push_pop_err: got err=%b want 00", err_sticky);
        else pass_cnt++;
        drive(1, 32'h300, 5'b10000, 0, 0, 0);
        total_cnt++;
        if ({err_sticky, fflags} !== {2'b10, 5'b0})
            $display("FAIL full_drop: got err=%b ff=%b want err=10 ff=00000", err_sticky, fflags);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 37'h0;
            total_cnt++;
            if ({out_valid, out_data, out_flags} !== {1'b1, exp})
                $display("FAIL drain_%0d: got v=%b %h want v=1 %h", i, out_valid,
                         {out_data, out_flags}, exp);
            else pass_cnt++;
            drive(0, 32'h0, 5'b0, 1, 0, 0);
        end
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL drain_empty: got v=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flags();
        do_reset();
        drive(1, 32'h1, 5'b01000, 1, 0, 0);
        drive(1, 32'h2, 5'b00001, 1, 0, 0);
        total_cnt++;
        if (fflags !== 5'b01001)
            $display("FAIL flags_accum: got %b want 01001", fflags);
        else pass_cnt++;
        drive(1, 32'h3, 5'b00001, 1, 0, 1);
        total_cnt++;
        if (fflags !== 5'b00001)
            $display("FAIL flags_clear_set: got %b want 00001", fflags);
        else pass_cnt++;
        drive(0, 32'h0, 5'b0, 1, 0, 0);
    endtask

    task automatic test_random();
        beat_t       pipe [$];
        beat_t       b, nb;
        logic [36:0] exp;
        logic        rdy, fire, pop;
        int          mres, seq, errs;
        logic [4:0]  mflags;
        do_reset();
        mres = 0; seq = 0; errs = 0; mflags = '0;
        for (int i = 0; i < int'(FP_RECIP_LATENCY); i++) pipe.push_back('0);
        for (int c = 0; c < 700; c++) begin
            rdy  = (c >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
            fire = (c < 600) && ($urandom_range(0, 1) == 1) && (mres < 16);
            b = pipe.pop_front();
            nb.v = fire; nb.d = 32'h4000_0000 + 32'(seq); nb.f = 5'($urandom);
            if (fire) seq++;
            pipe.push_back(nb);
            pop = out_valid && rdy;
            if (pop) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_unexpected: got %h want nothing", {out_data, out_flags});
                end else begin
                    exp = sb.pop_front();
                    if ({out_data, out_flags} !== exp)
                        $display("FAIL rand_order: got %h want %h", {out_data, out_flags}, exp);
                    else pass_cnt++;
                end
            end
            if (b.v) begin
                sb.push_back({b.d, b.f});
                mflags = mflags | b.f;
            end
            mres = mres + int'(fire) - int'(pop);
            drive(b.v, b.d, b.f, rdy, fire, 0);
            if (reserved !== CNT_W'(mres) || reserved > CNT_W'(16)) errs++;
        end
        total_cnt++;
        if (errs != 0) $display("FAIL rand_reserved: got %0d bad cycles want 0", errs);
        else pass_cnt++;
        total_cnt++;
        if ({err_sticky, fflags, reserved, out_valid} !== {2'b00, mflags, CNT_W'(0), 1'b0} ||
            sb.size() != 0)
            $display("FAIL rand_end: got err=%b ff=%b res=%0d v=%b left=%0d want 00 %b 0 0 0",
                     err_sticky, fflags, reserved, out_valid, sb.size(), mflags);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 9; i++) drive(i < 5, 32'h500 + 32'(i), 5'b00100, 0, 1, 0);
        total_cnt++;
        if ({reserved, out_valid, out_data, fflags} !== {CNT_W'(9), 1'b1, 32'h500, 5'b00100})
            $display("FAIL pre_reset: got res=%0d v=%b d=%h ff=%b want 9 1 500 00100",
                     reserved, out_valid, out_data, fflags);
        else pass_cnt++;
        issue_fire = 0; res_valid = 0;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, out_data, out_flags, fflags, reserved, err_sticky} !==
            {1'b0, 32'h0, 5'h0, 5'h0, CNT_W'(0), 2'b00})
            $display("FAIL async_reset: got v=%b d=%h f=%b ff=%b res=%0d err=%b want zeros",
                     out_valid, out_data, out_flags, fflags, reserved, err_sticky);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'hCAFE_F00D, 5'b00010, 0, 0, 0);
        drive(0, 32'h0, 5'b0, 0, 0, 0);
        total_cnt++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 32'hCAFE_F00D, 5'b00010})
            $display("FAIL post_reset_head: got v=%b %h %b want 1 cafef00d 00010",
                     out_valid, out_data, out_flags);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_credits();
        test_full_push();
        test_flags();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Sits directly downstream of the fp reciprocal pipeline, which cannot stall. It captures every result/flag beat from that pipeline into a FIFO and presents them to the consumer with valid/ready.
- Issues credits to the upstream issuer, so an operation is launched only when a FIFO slot is guaranteed. This makes FIFO overflow impossible under correct use.
- Accumulates sticky IEEE exception flags (fflags) for a CSR.

Parameters:
- DEPTH, 16, FIFO entries and credit limit; power of 2, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy and credit counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_fire  in  1  upstream launched one op into the pipeline this cycle
- issue_ok  out  1  a credit is available; upstream may fire
- res_valid  in  1  pipeline result beat (pipeline valid_data_out)
- res_data  in  32  result word
- res_flags  in  5  {invalid, div_by_zero, overflow, underflow, inexact}
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  32  head result
- out_flags  out  5  head flags
- fflags  out  5  sticky OR of accepted res_flags
- fflags_clear  in  1  clear sticky flags
- reserved  out  CNT_W  credits consumed: issued but not yet popped
- err_sticky  out  2  bit0 issue without credit; bit1 push into full FIFO

Behaviour:
- Reset (async, active-high): FIFO empty, pointers 0, reserved=0, fflags=0, err_sticky=0, out_valid=0. out_data and out_flags read 0 while empty.
- Credits:
  - issue_ok = (reserved < DEPTH), combinational from the register.
  - pop = out_valid & out_ready.
  - reserved_next = reserved + (issue_fire & issue_ok) − pop. Fire and pop in the same cycle leave it unchanged.
  - issue_fire while !issue_ok: counter unchanged, err_sticky[0] set.
- Push:
  - res_valid pushes {res_data, res_flags}.
  - When the FIFO is full, the push is accepted only if pop occurs in the same cycle; count is then unchanged and the head advances.
  - Otherwise the beat is dropped and err_sticky[1] is set.
- Latency: a beat pushed at edge N is visible on out_* after edge N (registered storage, no combinational bypass). The empty-to-valid latency is therefore 1 cycle.
- Pop: out_valid = (count != 0). out_data and out_flags equal the head entry. Pop at edge advances the read pointer.
- Pointers: log2(DEPTH)-bit, wrap naturally. Count is tracked separately, 0..DEPTH.
- Flags on an accepted push: fflags_next = (fflags_clear ? 0 : fflags) | res_flags. A clear and a flag arriving in the same cycle leave the new flags set. A dropped beat does not update fflags.
- err_sticky clears only on rst.
- Ordering: strictly in order; pipeline results arrive in issue order.
- No X on outputs at any time after reset.

Decomposition:
- fp_pkg additions:
  - typedef fp_flags_t, a packed struct {nv, dz, of, uf, nx}.
  - typedef fp_result_t, a packed struct {fp_32b_t value; fp_flags_t flags}.
  - localparam FP_RECIP_LATENCY, used by benches to model in-flight ops.
- Sub-module fp_sync_fifo (parameterised WIDTH, DEPTH). Interface: push, pop, din, dout, count, full, empty.
- The collector wraps fp_sync_fifo and adds the credit counter, sticky flags and error logic.

Test Plan:
- Reset with no traffic, then res_valid with data 0x3F000000 and flags 0 → next cycle out_valid=1, out_data=0x3F000000, fflags=0.
- Issue 16 ops back-to-back with out_ready=0 → reserved=16 and issue_ok=0. A 17th issue_fire → err_sticky=2'b01 and reserved stays 16. Pop one → issue_ok=1 next cycle.
- Push 16 beats with out_ready=0 → count=16. On a 17th beat with out_ready=1 in the same cycle → accepted, count stays 16, and head order is preserved on drain. A 17th beat with out_ready=0 → dropped, err_sticky[1]=1, and fflags are not updated by that beat.
- Push a beat with flags 5'b01000 (div-by-zero), then one with 5'b00001 → fflags=5'b01001. Assert fflags_clear in the same cycle as a beat with flags 5'b00001 → fflags=5'b00001.
- Random issue/pop streams modelled against the pipeline latency (FP_RECIP_LATENCY) → no err_sticky bits, output sequence equals input sequence, and reserved never exceeds 16.
- Assert rst mid-stream while count=5 and reserved=9 → all outputs go to 0 immediately (async), and the next beat after deassertion appears as the head.
